// File: rtl/serial_tx.sv
// serial_tx: frame transmitter sending start bit 0, DW data bits LSB first, then stop bit 1, each held DIV clocks
//   C     - clock, rising edge
//   Rn    - synchronous active-low reset, priority over start
//   start - send request, sampled only in IDLE
//   data  - word captured on the accepting edge
//   TXD   - registered serial line, idle high
//   busy  - registered, high for the (DW+2)*DIV cycles of a frame
//   done  - registered one-cycle pulse on the edge that returns to IDLE
module serial_tx #(
  parameter int DW  = 8,
  parameter int DIV = 4
) (
  input  logic          C,
  input  logic          Rn,
  input  logic          start,
  input  logic [DW-1:0] data,
  output logic          TXD,
  output logic          busy,
  output logic          done
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = DW > 1 ? $clog2(DW) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_state;
  logic [DW-1:0] r_shift, w_shift;
  logic [CW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic          w_tick, w_last, w_txd;
  assign w_tick = r_div == CW'(DIV - 1);
  assign w_last = r_bit == BW'(DW - 1);
  always_ff @(posedge C) begin
    if (!Rn) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      TXD     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_div   <= (r_state == IDLE || w_tick) ? '0 : r_div + CW'(1);
      r_bit   <= r_state == START ? '0 : (r_state == DATA && w_tick) ? r_bit + BW'(1) : r_bit;
      TXD     <= w_txd;
      busy    <= w_state != IDLE;
      done    <= r_state == STOP && w_tick;
    end
  end
  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    case (r_state)
      IDLE:    w_state = start ? START : IDLE;
      START:   w_state = w_tick ? DATA : START;
      DATA:    w_state = (w_tick && w_last) ? STOP : DATA;
      default: w_state = w_tick ? IDLE : STOP;
    endcase
    w_shift = (r_state == IDLE && start) ? data : (r_state == DATA && w_tick) ? r_shift >> 1 : r_shift;
  end
  // line value for the cycle after this edge, derived from where the FSM is heading
  always_comb begin
    w_txd = (w_state == DATA) ? w_shift[0] : (w_state != START);
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: randomized scoreboard bench for two serial_tx configurations (DW=8/DIV=4 and DW=4/DIV=1)
module tb_serial_tx;
  logic        clk = 1'b0;
  logic        rn = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [7:0]  d0 = '0;
  logic [3:0]  d1 = '0;
  wire  [1:0]  txd, busy, done;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [127:0] cap[2];
  int          cap_n[2];

  always #5 clk = ~clk;

  serial_tx #(.DW(8), .DIV(4)) u0 (.C(clk), .Rn(rn), .start(start[0]), .data(d0),
                                   .TXD(txd[0]), .busy(busy[0]), .done(done[0]));
  serial_tx #(.DW(4), .DIV(1)) u1 (.C(clk), .Rn(rn), .start(start[1]), .data(d1),
                                   .TXD(txd[1]), .busy(busy[1]), .done(done[1]));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference line waveform: one entry per clock, start 0, data LSB first, stop 1
  function automatic logic [127:0] frame(input logic [15:0] w, input int dw, input int dv);
    logic [127:0] r;
    int k;
    r = '0;
    k = 0;
    for (int b = -1; b <= dw; b++)
      for (int j = 0; j < dv; j++) begin
        r[k] = b < 0 ? 1'b0 : b == dw ? 1'b1 : w[b];
        k++;
      end
    return r;
  endfunction

  always @(negedge clk) begin
    int dw, dv, n;
    logic [15:0] w;
    for (int i = 0; i < 2; i++) begin
      dw = i == 0 ? 8 : 4;
      dv = i == 0 ? 4 : 1;
      if (done[i] === 1'b1) begin
        chk("done_busy_low", busy[i], 1'b0);
        n = i == 0 ? q0.size() : q1.size();
        chk("done_expected", n > 0, 1'b1);
        if (n > 0) begin
          if (i == 0) w = q0.pop_front();
          else w = q1.pop_front();
          chk("frame_len", cap_n[i], (dw + 2) * dv);
          chk("frame_bits", cap[i], frame(w, dw, dv));
        end
        cap[i] = '0;
        cap_n[i] = 0;
      end
      if (busy[i] === 1'b1) begin
        if (cap_n[i] < 128) cap[i][cap_n[i]] = txd[i];
        cap_n[i]++;
      end else if (rn) chk("idle_txd", txd[i], 1'b1);
    end
  end

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while (busy[i] !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 500, 1'b1);
  endtask

  task automatic send(input int i, input logic [15:0] w, input int hold);
    wait_idle(i);
    start[i] = 1'b1;
    if (i == 0) begin
      d0 = w[7:0];
      q0.push_back({8'h00, w[7:0]});
    end else begin
      d1 = w[3:0];
      q1.push_back({12'h000, w[3:0]});
    end
    repeat (hold) begin
      @(negedge clk);
      if (i == 0) d0 = 8'($urandom);
      else d1 = 4'($urandom);
    end
    start[i] = 1'b0;
  endtask

  initial begin
    int t;
    cap[0] = '0; cap[1] = '0; cap_n[0] = 0; cap_n[1] = 0;
    start = 2'b11;
    repeat (3) begin
      @(negedge clk);
      chk("rst_txd", txd, 2'b11);
      chk("rst_busy", busy, 2'b00);
      chk("rst_done", done, 2'b00);
    end
    rn = 1'b1;
    start = 2'b00;
    repeat (5) begin
      @(negedge clk);
      chk("no_spurious", busy, 2'b00);
    end
    send(0, 16'hA5, 1);
    send(0, 16'hFF, 1);
    repeat (9) @(negedge clk);
    start[0] = 1'b1;
    d0 = 8'h00;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    repeat (10) begin
      @(negedge clk);
      chk("no_second_frame", busy[0], 1'b0);
    end
    send(0, 16'hC3, 1);
    t = 0;
    while (done[0] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", t < 200, 1'b1);
    start[0] = 1'b1;
    d0 = 8'h3C;
    q0.push_back(16'h003C);
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_busy", busy[0], 1'b1);
    chk("b2b_txd", txd[0], 1'b0);
    send(0, 16'h5A, 1);
    repeat (17) @(negedge clk);
    rn = 1'b0;
    @(negedge clk);
    chk("abort_txd", txd[0], 1'b1);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    void'(q0.pop_front());
    cap[0] = '0;
    cap_n[0] = 0;
    rn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_done", done[0], 1'b0);
    end
    send(0, 16'h96, 2);
    for (int k = 0; k < 8; k++) begin
      send(0, 16'($urandom), $urandom_range(1, 5));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    send(1, 16'h0009, 1);
    for (int k = 0; k < 12; k++) begin
      send(1, 16'($urandom), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
